pulse_event_ctrl: RTL and testbench
===================================

PULSE_EVENT_CTRL -- requirements
Module: pulse_event_ctrl

Interface
REQ-001 Parameter CH, default 4, number of pulse input channels; legal range 2..8.
REQ-002 Parameter FILT_LEN, default 8, samples in each channel's filter window; legal range 2..16.
REQ-003 Parameter PRESCALE, default 16, clk cycles per sample tick; legal range 1..65535.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pulse_in  input  CH  raw asynchronous-origin pulse lines, one bit per channel.
REQ-007 ch_en  input  CH  per-channel event enable mask.
REQ-008 evt_ready  input  1  consumer accepts the presented event.
REQ-009 ovr_clr  input  CH  per-channel overrun clear strobe.
REQ-010 evt_valid  output  1  event presented.
REQ-011 evt_ch  output  clog2(CH)  channel index of the presented event.
REQ-012 evt_ts  output  32  timestamp of the presented event.
REQ-013 level  output  CH  filtered level per channel.
REQ-014 overrun  output  CH  sticky per-channel overrun flags.
REQ-015 busy  output  1  high when any pending bit is set or evt_valid is high.

Function
REQ-016 Prescaler counts 0..PRESCALE-1 and wraps; the sample tick is a one-cycle strobe asserted when the count equals PRESCALE-1 (every cycle when PRESCALE=1).
REQ-017 On each tick, each channel shifts pulse_in[i] into a FILT_LEN-bit shift register; no shift occurs between ticks.
REQ-018 level[i] is registered: it sets the cycle after the shift register becomes all ones, clears the cycle after it becomes all zeros, and otherwise holds (hysteresis).
REQ-019 A 0->1 transition of level[i] while ch_en[i]=1 is an edge event; a transition while ch_en[i]=0 is discarded; falling transitions never generate events.
REQ-020 An edge event sets pending[i]; if pending[i] is already set and not cleared in that cycle, overrun[i] sets instead and the earlier event is kept.
REQ-021 Arbiter FSM has states IDLE and PRESENT.
REQ-022 IDLE: when any pending bit is set, select the first set bit searching round-robin from last_grant+1 (mod CH), register evt_ch and evt_ts, drive evt_valid=1 on the next cycle, and enter PRESENT.
REQ-023 PRESENT: evt_valid, evt_ch and evt_ts are held stable until evt_ready=1; on handshake, clear pending[evt_ch], set last_grant=evt_ch, drive evt_valid=0 the next cycle, and return to IDLE.
REQ-024 Maximum throughput is one event per 2 cycles; the latency from a set pending bit to evt_valid, with the FSM in IDLE, is 1 cycle.
REQ-025 An edge event on channel c in the same cycle as the handshake for c leaves pending[c]=1 (new event) and does not set overrun[c].
REQ-026 When ovr_clr[i]=1 and an overrun condition on i occur in the same cycle, the set wins.
REQ-027 Pending edges on disabled channels remain queued; clearing ch_en does not flush pending.

Reset
REQ-028 While rst=0: prescaler, shift registers, level, pending, and overrun are 0; last_grant=CH-1; FSM is in IDLE; evt_valid=0, evt_ch=0, evt_ts=0, and busy=0.
REQ-029 Reset asserted in PRESENT drops evt_valid immediately (asynchronously) and discards all pending events.
REQ-030 After reset release, level[i] cannot rise until FILT_LEN ticks of ones have been sampled.

Configuration
REQ-031 With macro PULSE_EVT_TIMESTAMP_EN defined, a 32-bit free-running counter (reset 0, wraps) is captured per channel in the cycle its pending bit sets, and the captured value is presented on evt_ts.
REQ-032 Without PULSE_EVT_TIMESTAMP_EN, no counter or capture registers exist, and evt_ts is constant 0; all other behaviour is identical.

Verification
REQ-033 PRESCALE=4, FILT_LEN=8, ch0 high for 32 cycles -> level[0] rises after the 8th tick; exactly one event with evt_ch=0.
REQ-034 ch1 glitch high for 7 ticks then low -> level[1] stays 0, and no event occurs.
REQ-035 Edges on ch0, ch2, and ch3 in the same cycle, evt_ready held 1, last_grant=3 -> events are delivered in order 0, 2, 3, spaced 2 cycles apart.
REQ-036 evt_ready held 0 while ch2 produces a second edge -> overrun[2]=1 and evt_valid/evt_ch=2 stay stable; ovr_clr[2] pulse -> overrun[2]=0.
REQ-037 With PULSE_EVT_TIMESTAMP_EN defined, ch3 edge captured at counter value 100 -> evt_ts=100; without the macro -> evt_ts=0.
REQ-038 rst pulsed low while in PRESENT with 2 pending -> evt_valid=0 asynchronously, busy=0, and no events after release.

Source files
------------

// File: rtl/pulse_event_ctrl.sv
// Pulse event controller: prescaled sampling, per-channel hysteresis filter, round-robin event arbiter (PULSE_EVT_TIMESTAMP_EN adds timestamps).
// Latency: evt_valid rises 1 cycle after a pending bit sets in IDLE; at most one event per 2 cycles.
// Backpressure: event held stable until evt_ready; a new edge on a still-pending channel sets its sticky overrun flag.
module pulse_event_ctrl #(
    parameter int CH       = 4,
    parameter int FILT_LEN = 8,
    parameter int PRESCALE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         pulse_in,
    input  logic [CH-1:0]         ch_en,
    input  logic                  evt_ready,
    input  logic [CH-1:0]         ovr_clr,
    output logic                  evt_valid,
    output logic [$clog2(CH)-1:0] evt_ch,
    output logic [31:0]           evt_ts,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         overrun,
    output logic                  busy
);
    localparam int CW = $clog2(CH);

    typedef enum logic {IDLE, PRESENT} state_t;

    logic [15:0]                  presc_q, presc_d;
    logic                         tick;
    logic [CH-1:0][FILT_LEN-1:0]  sr_q, sr_d;
    logic [CH-1:0]                level_q, level_d;
    logic [CH-1:0]                rise;
    logic [CH-1:0]                pend_q, pend_d, pend_keep;
    logic [CH-1:0]                ovr_q, ovr_d;
    logic [CH-1:0]                grant_clr;
    logic                         hs;
    state_t                       state_q, state_d;
    logic [CW-1:0]                evt_ch_q, evt_ch_d;
    logic [CW-1:0]                last_grant_q, last_grant_d;
    logic [CW-1:0]                pick;

    // Nearest requester after 'last' wins; 'last' itself has lowest priority.
    function automatic logic [CW-1:0] rr_pick(input logic [CH-1:0] req, input logic [CW-1:0] last);
        logic [CW-1:0] sel;
        int            j;
        sel = '0;
        for (int k = CH; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= CH) j = j - CH;
            if (req[CW'(j)]) sel = CW'(j);
        end
        return sel;
    endfunction

    always_comb begin
        tick    = (presc_q == 16'(PRESCALE - 1));
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    assign hs = (state_q == PRESENT) && evt_ready;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign sr_d[g]      = tick ? {sr_q[g][FILT_LEN-2:0], pulse_in[g]} : sr_q[g];
        assign level_d[g]   = (&sr_q[g])  ? 1'b1 :
                              (~|sr_q[g]) ? 1'b0 : level_q[g];
        assign grant_clr[g] = hs && (evt_ch_q == CW'(g));
    end

    // A handshake clearing a channel frees its slot for an edge arriving in the same cycle.
    always_comb begin
        rise      = level_d & ~level_q & ch_en;
        pend_keep = pend_q & ~grant_clr;
        pend_d    = pend_keep | rise;
        ovr_d     = (ovr_q & ~ovr_clr) | (rise & pend_keep);
    end

    assign pick = rr_pick(pend_q, last_grant_q);

    always_comb begin
        state_d      = state_q;
        evt_ch_d     = evt_ch_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    evt_ch_d = pick;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    last_grant_d = evt_ch_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            sr_q         <= '0;
            level_q      <= '0;
            pend_q       <= '0;
            ovr_q        <= '0;
            state_q      <= IDLE;
            evt_ch_q     <= '0;
            last_grant_q <= CW'(CH - 1);
        end else begin
            presc_q      <= presc_d;
            sr_q         <= sr_d;
            level_q      <= level_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            state_q      <= state_d;
            evt_ch_q     <= evt_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef PULSE_EVT_TIMESTAMP_EN
    logic [31:0]          ts_cnt_q;
    logic [CH-1:0][31:0]  cap_q, cap_d;
    logic [CH-1:0]        cap_en;
    logic [31:0]          evt_ts_q, evt_ts_d;

    // Capture only when the pending bit actually takes a new event (not on overrun).
    assign cap_en = rise & ~pend_keep;

    for (genvar g = 0; g < CH; g++) begin : g_cap
        assign cap_d[g] = cap_en[g] ? ts_cnt_q : cap_q[g];
    end

    assign evt_ts_d = ((state_q == IDLE) && (|pend_q)) ? cap_q[pick] : evt_ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_q <= '0;
            cap_q    <= '0;
            evt_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            cap_q    <= cap_d;
            evt_ts_q <= evt_ts_d;
        end
    end

    assign evt_ts = evt_ts_q;
`else
    assign evt_ts = 32'd0;
`endif

    assign evt_valid = (state_q == PRESENT);
    assign evt_ch    = evt_ch_q;
    assign level     = level_q;
    assign overrun   = ovr_q;
    assign busy      = (|pend_q) || evt_valid;

endmodule

// File: tb/tb_pulse_event_ctrl.sv
// Bench for pulse_event_ctrl: directed scenarios plus randomized pulses, checked by a scoreboard fed from a sample-history model.
module tb_pulse_event_ctrl;
    localparam int CH       = 4;
    localparam int FILT_LEN = 8;
    localparam int PRESCALE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pulse_in;
    logic [CH-1:0] ch_en;
    logic          evt_ready;
    logic [CH-1:0] ovr_clr;
    logic          evt_valid;
    logic [1:0]    evt_ch;
    logic [31:0]   evt_ts;
    logic [CH-1:0] level;
    logic [CH-1:0] overrun;
    logic          busy;

    pulse_event_ctrl #(.CH(CH), .FILT_LEN(FILT_LEN), .PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .ch_en     (ch_en),
        .evt_ready (evt_ready),
        .ovr_clr   (ovr_clr),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ts    (evt_ts),
        .level     (level),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level follows the run length of identical samples.
    logic [CH-1:0] lvl_m, pend_m, ovr_m;
    int            ones_run [CH];
    int            zero_run [CH];
    int unsigned   cyc;
    logic [31:0]   exp_q [CH][$];

    always @(negedge clk) begin : model
        logic tick_m, hs_m, nl, ev, hsc;
        if (!rst) begin
            lvl_m  = '0;
            pend_m = '0;
            ovr_m  = '0;
            cyc    = 0;
            for (int c = 0; c < CH; c++) begin
                ones_run[c] = 0;
                zero_run[c] = FILT_LEN;
                exp_q[c].delete();
            end
        end
        chk("level", level, lvl_m);
        chk("overrun", overrun, ovr_m);
        chk("busy", busy, |pend_m);
        if (rst) begin
            tick_m = ((cyc % PRESCALE) == PRESCALE - 1);
            hs_m   = evt_valid && evt_ready;
            for (int c = 0; c < CH; c++) begin
                nl = lvl_m[c];
                if (ones_run[c] >= FILT_LEN)      nl = 1'b1;
                else if (zero_run[c] >= FILT_LEN) nl = 1'b0;
                ev  = nl && !lvl_m[c] && ch_en[c];
                hsc = hs_m && (int'(evt_ch) == c);
                if (ev) begin
                    if (pend_m[c] && !hsc) begin
                        ovr_m[c] = 1'b1;
                    end else begin
                        pend_m[c] = 1'b1;
`ifdef PULSE_EVT_TIMESTAMP_EN
                        exp_q[c].push_back(cyc);
`else
                        exp_q[c].push_back(32'd0);
`endif
                    end
                end else if (hsc) begin
                    pend_m[c] = 1'b0;
                end
                if (ovr_clr[c] && !(ev && pend_m[c] && !hsc)) ovr_m[c] = 1'b0;
                lvl_m[c] = nl;
                if (tick_m) begin
                    if (pulse_in[c]) begin
                        ones_run[c]++;
                        zero_run[c] = 0;
                    end else begin
                        zero_run[c]++;
                        ones_run[c] = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic          prev_hold;
    logic [1:0]    prev_ch;
    logic [31:0]   prev_ts;
    logic [31:0]   mon_e;
    int unsigned   mon_cyc;
    int            log_ch [$];
    int unsigned   log_cyc [$];
    logic [31:0]   log_ts [$];

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
            mon_cyc   = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", evt_valid, 1);
                chk("hold_ch", evt_ch, prev_ch);
                chk("hold_ts", evt_ts, prev_ts);
            end
            if (evt_valid && evt_ready) begin
                if (exp_q[evt_ch].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got ch %0d, expected none at %0t", evt_ch, $time);
                end else begin
                    mon_e = exp_q[evt_ch].pop_front();
                    chk("evt_ts", evt_ts, mon_e);
                end
                log_ch.push_back(int'(evt_ch));
                log_cyc.push_back(mon_cyc);
                log_ts.push_back(evt_ts);
            end
            prev_hold = evt_valid && !evt_ready;
            prev_ch   = evt_ch;
            prev_ts   = evt_ts;
            mon_cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align();
        int guard = 0;
        while ((cyc % PRESCALE) != 0 && guard < PRESCALE) begin
            step(1);
            guard++;
        end
    endtask

    task automatic clear_log();
        log_ch.delete();
        log_cyc.delete();
        log_ts.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        logic rdy_lo;
        rdy_lo    = 1'b0;
        rst       = 1'b0;
        pulse_in  = '0;
        ch_en     = '1;
        evt_ready = 1'b1;
        ovr_clr   = '0;
        step(2);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ch", evt_ch, 0);
        chk("rst_ts", evt_ts, 0);
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // Long pulse on ch0: level rises right after the 8th tick, one event.
        pulse_in = 4'b0001;
        rst      = 1'b1;
        clear_log();
        step(32);
        chk("lvl0_before_rise", level[0], 0);
        step(1);
        chk("lvl0_after_rise", level[0], 1);
        pulse_in = '0;
        step(40);
        chk("ch0_evt_count", log_ch.size(), 1);
        if (log_ch.size() >= 1) chk("ch0_evt_ch", log_ch[0], 0);

        // Glitch of 7 ticks on ch1: no level change, no event.
        clear_log();
        align();
        pulse_in = 4'b0010;
        step(7 * PRESCALE);
        pulse_in = '0;
        step(2);
        chk("glitch_level1", level[1], 0);
        step(40);
        chk("glitch_evt_count", log_ch.size(), 0);

        // Simultaneous edges on 0,2,3 from last_grant=3.
        rst = 1'b0;
        step(2);
        pulse_in = 4'b1101;
        rst      = 1'b1;
        clear_log();
        step(33);
        chk("lat_busy", busy, 1);
        chk("lat_valid_pre", evt_valid, 0);
        step(1);
        chk("lat_valid", evt_valid, 1);
        chk("lat_ch", evt_ch, 0);
        pulse_in = '0;
        step(40);
        chk("rr_count", log_ch.size(), 3);
        if (log_ch.size() == 3) begin
            chk("rr_order0", log_ch[0], 0);
            chk("rr_order1", log_ch[1], 2);
            chk("rr_order2", log_ch[2], 3);
            chk("rr_gap01", log_cyc[1] - log_cyc[0], 2);
            chk("rr_gap12", log_cyc[2] - log_cyc[1], 2);
        end

        // Overrun on ch2 while the first event is held.
        clear_log();
        evt_ready = 1'b0;
        align();
        pulse_in = 4'b0100;
        step(34);
        chk("ovr_first_valid", evt_valid, 1);
        chk("ovr_first_ch", evt_ch, 2);
        pulse_in = '0;
        step(40);
        align();
        pulse_in = 4'b0100;
        step(34);
        chk("ovr_set", overrun, 4'b0100);
        chk("ovr_held_valid", evt_valid, 1);
        chk("ovr_held_ch", evt_ch, 2);
        ovr_clr = 4'b0100;
        step(1);
        ovr_clr = '0;
        chk("ovr_cleared", overrun, 0);
        evt_ready = 1'b1;
        pulse_in  = '0;
        step(40);
        chk("ovr_evt_count", log_ch.size(), 1);

        // Timestamp capture at counter value 100 on ch3.
        do_reset();
        clear_log();
        step(70);
        pulse_in = 4'b1000;
        step(40);
        pulse_in = '0;
        chk("ts_evt_count", log_ch.size(), 1);
        if (log_ch.size() == 1) begin
            chk("ts_evt_ch", log_ch[0], 3);
`ifdef PULSE_EVT_TIMESTAMP_EN
            chk("ts_value", log_ts[0], 100);
`else
            chk("ts_value", log_ts[0], 0);
`endif
        end
        step(40);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) pulse_in[c] = ~pulse_in[c];
                ovr_clr[c] = ($urandom_range(0, 49) == 0);
            end
            if ($urandom_range(0, 199) == 0) ch_en = CH'($urandom);
            if ((n % 100) == 0) rdy_lo = ($urandom_range(0, 2) == 0);
            evt_ready = rdy_lo ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            step(1);
        end
        pulse_in  = '0;
        ovr_clr   = '0;
        evt_ready = 1'b1;
        step(60);
        for (int c = 0; c < CH; c++) chk("drain_empty", exp_q[c].size(), 0);
        chk("drain_busy", busy, 0);

        // Reset while presenting with two pending events.
        ch_en     = '1;
        evt_ready = 1'b0;
        pulse_in  = 4'b0011;
        step(40);
        chk("pre_rst_valid", evt_valid, 1);
        rst = 1'b0;
        #2;
        chk("async_rst_valid", evt_valid, 0);
        chk("async_rst_busy", busy, 0);
        pulse_in = '0;
        step(3);
        rst = 1'b1;
        clear_log();
        evt_ready = 1'b1;
        step(100);
        chk("post_rst_events", log_ch.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
